mips_seq_divider: RTL and testbench
===================================

Name: mips_seq_divider

Overview:
- Multi-cycle 32-bit integer divider for MIPS DIV/DIVU; writes HI (remainder) and LO (quotient).
- Inverse of the combinational add path: restoring shift-subtract, one quotient bit per clock.
- Sits beside the ALU in EX stage; pipeline stalls on busy and consumes results on done.

Parameters:
- WIDTH, 32, operand/result width in bits (even, >=4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state and outputs.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  input  WIDTH  sampled with start.
- divisor  input  WIDTH  sampled with start.
- busy  output  1  high from edge after accepted start until the done edge.
- done  output  1  one-cycle pulse; quotient/remainder valid from this cycle.
- quotient  output  WIDTH  LO result; held until the next done.
- remainder  output  WIDTH  HI result; held until the next done.
- div_by_zero  output  1  valid with done; held with results.

Behaviour:
- Reset (synchronous, active-high, any state incl. mid-operation): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; counter and internal registers cleared. In-flight op discarded, no done.
- States: IDLE, ITER, FINISH.
- IDLE: on edge with start=1 latch sign flags (neg_q = is_signed & (dividend[MSB] ^ divisor[MSB]); neg_r = is_signed & dividend[MSB]); load magnitudes |dividend|, |divisor| (magnitude only when is_signed); partial remainder=0; counter=0; busy=1. Divisor==0 -> FINISH; else -> ITER.
- ITER: each edge shift {rem,quo} left 1, trial = rem_shifted - |divisor| (WIDTH+1 bits); if trial non-negative, rem=trial and quotient LSB=1, else keep and LSB=0. counter++; after WIDTH iterations -> FINISH.
- FINISH (one cycle): quotient = neg_q ? -q : q; remainder = neg_r ? -r : r; done=1 for exactly this cycle; busy=0 on the same edge done rises; -> IDLE.
- Latency: start sampled at edge E0; done high after edge E0+WIDTH+1 (33 edges at WIDTH=32). Divide-by-zero: done after E0+1.
- Divide by zero: quotient = all ones, remainder = original dividend (unmodified), div_by_zero=1. Otherwise div_by_zero=0.
- Signed overflow (most-negative / -1): quotient = 0x80000000, remainder = 0, div_by_zero=0; falls out of the magnitude algorithm, no special case.
- Truncation toward zero; remainder sign follows dividend; |remainder| < |divisor|.
- start while busy or during FINISH: ignored, no queueing. Back-to-back: start in the cycle after done is accepted.
- Operand inputs may change freely after the start edge.

Optional Feature:
- Macro DIV_EARLY_EXIT_EN.
- Defined: in IDLE, if divisor!=0 and |dividend| < |divisor| (unsigned compare of magnitudes), skip ITER and go to FINISH with q=0, r=|dividend| (sign-corrected → remainder = dividend); done after E0+1.
- Undefined: every non-zero-divisor op takes full WIDTH+1 latency; results are identical in both builds.

Test Plan:
- DIVU 100 / 7, start at E0 -> done pulse after E0+33, quotient=14, remainder=2, div_by_zero=0, busy high exactly 33 cycles.
- DIV 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); DIV 7 / 0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
- DIVU 5 / 0 -> done after E0+1, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
- Start DIVU 1000/3, assert reset at cycle 10 -> next edge busy=0, done never pulses, outputs=0. Start 50/5 next cycle -> q=10, r=0.
- Pulse start again at cycles 5 and 20 of a running op -> ignored, single done with original result. With DIV_EARLY_EXIT_EN: DIVU 3/10 -> done after E0+1, q=0, r=3.

Source files
------------

// File: rtl/mips_seq_divider.sv
// ============================================================================
// Module   : mips_seq_divider
// Brief    : Restoring shift-subtract divider for MIPS DIV/DIVU. It produces
//            one quotient bit per clock and writes LO (quotient) and HI
//            (remainder).
//            Optional macro DIV_EARLY_EXIT_EN: finishes at once when
//            |dividend| < |divisor|.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ITER   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_rem, w_rem_nxt;
    logic [WIDTH-1:0] r_quo, w_quo_nxt;
    logic [WIDTH-1:0] r_dvs, w_dvs_nxt;
    logic             r_neg_q, w_neg_q_nxt;
    logic             r_neg_r, w_neg_r_nxt;
    logic             r_dz, w_dz_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic             w_busy_nxt, w_done_nxt, w_dz_out_nxt;
    logic [WIDTH-1:0] w_quotient_nxt, w_remainder_nxt;

    logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
    logic [WIDTH:0]   w_shift, w_trial;

    // Magnitudes are only taken for DIV; DIVU operands pass through untouched.
    assign w_dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // The partial remainder stays below the divisor, so the shifted value
    // always fits in WIDTH+1 bits and the trial's MSB acts as the borrow.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};

    always_comb begin
        w_state_nxt     = r_state;
        w_rem_nxt       = r_rem;
        w_quo_nxt       = r_quo;
        w_dvs_nxt       = r_dvs;
        w_neg_q_nxt     = r_neg_q;
        w_neg_r_nxt     = r_neg_r;
        w_dz_nxt        = r_dz;
        w_cnt_nxt       = r_cnt;
        w_busy_nxt      = busy;
        w_done_nxt      = 1'b0;
        w_dz_out_nxt    = div_by_zero;
        w_quotient_nxt  = quotient;
        w_remainder_nxt = remainder;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_busy_nxt = 1'b1;
                    w_cnt_nxt  = '0;
                    if (divisor == '0) begin
                        // Divide by zero: the dividend is reported unmodified,
                        // so the sign fix-up is suppressed.
                        w_rem_nxt   = dividend;
                        w_quo_nxt   = '1;
                        w_dvs_nxt   = '0;
                        w_neg_q_nxt = 1'b0;
                        w_neg_r_nxt = 1'b0;
                        w_dz_nxt    = 1'b1;
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_neg_q_nxt = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        w_neg_r_nxt = is_signed & dividend[WIDTH-1];
                        w_dz_nxt    = 1'b0;
                        w_dvs_nxt   = w_dvs_mag;
                        w_rem_nxt   = '0;
                        w_quo_nxt   = w_dvd_mag;
                        w_state_nxt = S_ITER;
`ifdef DIV_EARLY_EXIT_EN
                        if (w_dvd_mag < w_dvs_mag) begin
                            w_rem_nxt   = w_dvd_mag;
                            w_quo_nxt   = '0;
                            w_state_nxt = S_FINISH;
                        end
`endif
                    end
                end
            end

            S_ITER: begin
                if (!w_trial[WIDTH]) begin
                    w_rem_nxt = w_trial[WIDTH-1:0];
                    w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
                end else begin
                    w_rem_nxt = w_shift[WIDTH-1:0];
                    w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
                end
                w_cnt_nxt = r_cnt + C_CNT_ONE;
                if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = S_FINISH;
                end
            end

            S_FINISH: begin
                w_quotient_nxt  = r_neg_q ? -r_quo : r_quo;
                w_remainder_nxt = r_neg_r ? -r_rem : r_rem;
                w_dz_out_nxt    = r_dz;
                w_done_nxt      = 1'b1;
                w_busy_nxt      = 1'b0;
                w_state_nxt     = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dz        <= 1'b0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rem       <= w_rem_nxt;
            r_quo       <= w_quo_nxt;
            r_dvs       <= w_dvs_nxt;
            r_neg_q     <= w_neg_q_nxt;
            r_neg_r     <= w_neg_r_nxt;
            r_dz        <= w_dz_nxt;
            r_cnt       <= w_cnt_nxt;
            busy        <= w_busy_nxt;
            done        <= w_done_nxt;
            quotient    <= w_quotient_nxt;
            remainder   <= w_remainder_nxt;
            div_by_zero <= w_dz_out_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_seq_divider.sv
// ============================================================================
// Module   : tb_mips_seq_divider
// Brief    : Self-checking bench for mips_seq_divider. Directed and random
//            operations are compared against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_seq_divider;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    mips_seq_divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference: MIPS semantics expressed with native integer division.
    task automatic ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r,
                           output logic dz, output int lat);
        int     sa, sb;
        longint ma, mb;
        sa  = $signed(a);
        sb  = $signed(b);
        dz  = 1'b0;
        lat = WIDTH + 1;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 1;
        end else if (!s) begin
            q = a / b; r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 0;
        end else begin
            q = 32'(sa / sb); r = 32'(sa % sb);
        end
        ma = s ? longint'(sa) : longint'(a);
        mb = s ? longint'(sb) : longint'(b);
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_EXIT_EN
        if (b != 0 && ma < mb) lat = 1;
`else
        if (ma < 0 || mb < 0) lat = -1;
`endif
    endtask

    task automatic do_op(input string tag, input bit s, input logic [31:0] a,
                         input logic [31:0] b, input bit inject);
        logic [31:0] eq, er;
        logic        edz;
        int          elat, cycles, busy_cnt;
        ref_div(s, a, b, eq, er, edz, elat);
        @(negedge clock);
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        @(posedge clock); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        cycles = 0; busy_cnt = 0;
        while (!done && cycles < 100) begin
            if (busy) busy_cnt++;
            if (inject && (cycles == 5 || cycles == 20)) begin
                start = 1'b1; is_signed = ~s; dividend = 32'd77; divisor = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clock); #1;
            cycles++;
        end
        start = 1'b0;
        check_val({tag, "_latency"}, cycles, elat);
        check_val({tag, "_busy_cycles"}, busy_cnt, elat);
        check_val({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        check_val({tag, "_q"}, quotient, eq);
        check_val({tag, "_r"}, remainder, er);
        check_val({tag, "_dz"}, {31'b0, div_by_zero}, {31'b0, edz});
        @(posedge clock); #1;
        check_val({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check_val({tag, "_q_held"}, quotient, eq);
    endtask

    initial begin
        int          pulses;
        logic [31:0] ra, rb;
        bit          rs;
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clock);
        #1;
        check_val("rst_busy", {31'b0, busy}, 32'd0);
        check_val("rst_done", {31'b0, done}, 32'd0);
        check_val("rst_q", quotient, 32'd0);
        check_val("rst_r", remainder, 32'd0);
        check_val("rst_dz", {31'b0, div_by_zero}, 32'd0);
        reset = 1'b0;

        do_op("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
        do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        do_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("divu_5_0", 1'b0, 32'd5, 32'd0, 1'b0);
        do_op("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);
        do_op("divu_3_10", 1'b0, 32'd3, 32'd10, 1'b0);
        do_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_op("div_min_1", 1'b1, 32'h8000_0000, 32'd1, 1'b0);
        do_op("inject", 1'b0, 32'd123456, 32'd789, 1'b1);

        // Reset in the middle of an operation discards it.
        @(negedge clock);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_val("midrst_busy", {31'b0, busy}, 32'd0);
        check_val("midrst_q", quotient, 32'd0);
        check_val("midrst_r", remainder, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (done) pulses++;
        end
        check_val("midrst_no_done", pulses, 32'd0);
        do_op("after_rst_50_5", 1'b0, 32'd50, 32'd5, 1'b0);

        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom_range(0, 15);
                1:       rb = -$urandom_range(1, 15);
                2:       rb = ra >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            do_op($sformatf("rand%0d", i), rs, ra, rb, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
